// File: rtl/spi_reg_writer.sv
// spi_reg_writer: SPI mode-0 target that writes 16-bit frames
// {R/W, addr[6:0], data[7:0]} into a small bank of 8-bit control registers.
// The SPI pins are sampled by the system clock through synchronizers.
// Every write that is committed produces a one-cycle wr_strobe.
// Every frame that is discarded produces a one-cycle err_strobe.
module spi_reg_writer #(
   parameter int SYNC_STAGES = 2,
   parameter int NUM_REGS    = 5
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       sclk,
   input  logic       copi,
   input  logic       ncs,
   output logic [7:0] en_reg_out_7_0,
   output logic [7:0] en_reg_out_15_8,
   output logic [7:0] en_reg_pwm_7_0,
   output logic [7:0] en_reg_pwm_15_8,
   output logic [7:0] pwm_duty_cycle,
   output logic       wr_strobe,
   output logic       err_strobe
);

   typedef enum logic [1:0] {WAIT_HIGH, IDLE, SHIFT, COMMIT} state_t;

   state_t state_reg, state_next;

   logic [SYNC_STAGES-1:0] sclk_sync_reg, copi_sync_reg, ncs_sync_reg;
   logic [SYNC_STAGES:0]   prime_reg;
   logic                   sclk_prev_reg, ncs_prev_reg;
   logic                   sclk_s, copi_s, ncs_s;
   logic                   sclk_rise, ncs_rise, ncs_fall;

   logic [15:0] shift_reg;
   logic [4:0]  count_reg;
   logic [6:0]  frame_addr;
   logic [7:0]  frame_data;
   logic        addr_ok;

   logic        clear_en, shift_en, commit_wr, commit_err;

   logic [7:0]  regs_reg [NUM_REGS];
   logic [7:0]  reg_view [5];

   // Input synchronizers. The ncs flops reset high so that the chip select reads as deselected.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sclk_sync_reg <= '0;
         copi_sync_reg <= '0;
         ncs_sync_reg  <= '1;
      end else begin
         sclk_sync_reg <= {sclk_sync_reg[SYNC_STAGES-2:0], sclk};
         copi_sync_reg <= {copi_sync_reg[SYNC_STAGES-2:0], copi};
         ncs_sync_reg  <= {ncs_sync_reg[SYNC_STAGES-2:0], ncs};
      end
   end

   assign sclk_s = sclk_sync_reg[SYNC_STAGES-1];
   assign copi_s = copi_sync_reg[SYNC_STAGES-1];
   assign ncs_s  = ncs_sync_reg[SYNC_STAGES-1];

   // Previous-cycle copies for edge detection, plus a fill marker for the synchronizer chain.
   // The ncs chain holds its reset value of 1 until real samples reach the end of the chain.
   // WAIT_HIGH therefore waits for prime_reg to fill. Otherwise a chip select held low through
   // reset would look high for a moment and then show a false falling edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sclk_prev_reg <= 1'b0;
         ncs_prev_reg  <= 1'b1;
         prime_reg     <= '0;
      end else begin
         sclk_prev_reg <= sclk_s;
         ncs_prev_reg  <= ncs_s;
         prime_reg     <= {prime_reg[SYNC_STAGES-1:0], 1'b1};
      end
   end

   assign sclk_rise = sclk_s & ~sclk_prev_reg;
   assign ncs_rise  = ncs_s & ~ncs_prev_reg;
   assign ncs_fall  = ~ncs_s & ncs_prev_reg;

   assign frame_addr = shift_reg[14:8];
   assign frame_data = shift_reg[7:0];
   assign addr_ok    = ({25'd0, frame_addr} < 32'(NUM_REGS));

   // FSM state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_reg <= WAIT_HIGH;
      else     state_reg <= state_next;
   end

   // FSM next-state logic.
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         WAIT_HIGH: if (prime_reg[SYNC_STAGES] && ncs_s) state_next = IDLE;
         IDLE:      if (ncs_fall) state_next = SHIFT;
         SHIFT:     if (ncs_rise) state_next = COMMIT;
         COMMIT:    state_next = IDLE;
         default:   state_next = WAIT_HIGH;
      endcase
   end

   // FSM output decode. In SHIFT an ncs rise takes priority over an sclk rise.
   // A complete read frame is dropped without any strobe.
   always_comb begin
      clear_en   = 1'b0;
      shift_en   = 1'b0;
      commit_wr  = 1'b0;
      commit_err = 1'b0;
      case (state_reg)
         IDLE:    clear_en = ncs_fall;
         SHIFT:   shift_en = sclk_rise & ~ncs_rise & ~ncs_s;
         COMMIT: begin
            if (count_reg != 5'd16)
               commit_err = 1'b1;
            else if (shift_reg[15] && addr_ok)
               commit_wr = 1'b1;
            else if (shift_reg[15])
               commit_err = 1'b1;
         end
         default: ;
      endcase
   end

   // Frame shift register and bit counter. The counter saturates so that overlong frames stay invalid.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         shift_reg <= '0;
         count_reg <= '0;
      end else if (clear_en) begin
         shift_reg <= '0;
         count_reg <= '0;
      end else if (shift_en) begin
         shift_reg <= {shift_reg[14:0], copi_s};
         if (count_reg != 5'd31) count_reg <= count_reg + 5'd1;
      end
   end

   // Register bank and strobes. Both update on the edge that ends COMMIT.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_strobe  <= 1'b0;
         err_strobe <= 1'b0;
         for (int i = 0; i < NUM_REGS; i++) regs_reg[i] <= 8'h00;
      end else begin
         wr_strobe  <= commit_wr;
         err_strobe <= commit_err;
         for (int i = 0; i < NUM_REGS; i++) begin
            if (commit_wr && frame_addr == 7'(i)) regs_reg[i] <= frame_data;
         end
      end
   end

   // Map the bank onto the five named outputs. Addresses beyond NUM_REGS read as zero.
   genvar gi;
   generate
      for (gi = 0; gi < 5; gi++) begin : g_view
         if (gi < NUM_REGS) begin : g_live
            assign reg_view[gi] = regs_reg[gi];
         end else begin : g_zero
            assign reg_view[gi] = 8'h00;
         end
      end
   endgenerate

   assign en_reg_out_7_0  = reg_view[0];
   assign en_reg_out_15_8 = reg_view[1];
   assign en_reg_pwm_7_0  = reg_view[2];
   assign en_reg_pwm_15_8 = reg_view[3];
   assign pwm_duty_cycle  = reg_view[4];

endmodule

// File: tb/tb_spi_reg_writer.sv
// Directed testbench for spi_reg_writer.
// The clock runs at 10x the SPI bit rate. Each frame checks the register values and the strobe counts.
module tb_spi_reg_writer;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       sclk = 1'b0;
   logic       copi = 1'b0;
   logic       ncs = 1'b1;
   logic [7:0] en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8, pwm_duty_cycle;
   logic       wr_strobe, err_strobe;

   int tests = 0;
   int fails = 0;
   int wr_total = 0;
   int err_total = 0;
   int both_total = 0;

   spi_reg_writer #(.SYNC_STAGES(2), .NUM_REGS(5)) dut (
      .clk(clk), .rst(rst), .sclk(sclk), .copi(copi), .ncs(ncs),
      .en_reg_out_7_0(en_reg_out_7_0), .en_reg_out_15_8(en_reg_out_15_8),
      .en_reg_pwm_7_0(en_reg_pwm_7_0), .en_reg_pwm_15_8(en_reg_pwm_15_8),
      .pwm_duty_cycle(pwm_duty_cycle), .wr_strobe(wr_strobe), .err_strobe(err_strobe)
   );

   always #5 clk = ~clk;

   // Count strobe pulses away from the active edge
   always @(negedge clk) begin
      if (wr_strobe) wr_total++;
      if (err_strobe) err_total++;
      if (wr_strobe && err_strobe) both_total++;
   end

   function automatic logic [39:0] regs_now();
      return {en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8, pwm_duty_cycle};
   endfunction

   task automatic begin_frame();
      @(negedge clk) ncs = 1'b0;
      repeat (10) @(negedge clk);
   endtask

   task automatic send_bits(input logic [15:0] f, input int first, input int last);
      for (int i = first; i <= last; i++) begin
         copi = f[15-i];
         repeat (5) @(negedge clk);
         sclk = 1'b1;
         repeat (5) @(negedge clk);
         sclk = 1'b0;
      end
   endtask

   task automatic end_frame();
      repeat (5) @(negedge clk);
      ncs = 1'b1;
      repeat (14) @(negedge clk);
   endtask

   task automatic send_frame(input logic [15:0] f, input int nbits);
      begin_frame();
      send_bits(f, 0, nbits - 1);
      end_frame();
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      tests++;
      if (regs_now() !== 40'h0) begin
         fails++; $display("FAIL reset_regs: got %h want %h", regs_now(), 40'h0);
      end
      tests++;
      if ({wr_strobe, err_strobe} !== 2'b00) begin
         fails++; $display("FAIL reset_strobes: got %b want 00", {wr_strobe, err_strobe});
      end
      rst = 1'b0;
      repeat (10) @(negedge clk);
   endtask

   task automatic test_pwm_write();
      int w0, e0;
      w0 = wr_total; e0 = err_total;
      send_frame(16'h8455, 16);
      tests++;
      if (regs_now() !== 40'h00_00_00_00_55) begin
         fails++; $display("FAIL pwm_write_regs: got %h want %h", regs_now(), 40'h55);
      end
      tests++;
      if (wr_total - w0 !== 1) begin
         fails++; $display("FAIL pwm_write_wr: got %0d want 1", wr_total - w0);
      end
      tests++;
      if (err_total - e0 !== 0) begin
         fails++; $display("FAIL pwm_write_err: got %0d want 0", err_total - e0);
      end
   endtask

   task automatic test_back_to_back();
      int w0;
      w0 = wr_total;
      send_frame(16'h80F0, 16);
      send_frame(16'h8100, 16);
      tests++;
      if (regs_now() !== 40'hF0_00_00_00_55) begin
         fails++; $display("FAIL b2b_regs: got %h want %h", regs_now(), 40'hF0_00_00_00_55);
      end
      tests++;
      if (wr_total - w0 !== 2) begin
         fails++; $display("FAIL b2b_wr: got %0d want 2", wr_total - w0);
      end
   endtask

   task automatic test_invalid();
      int w0, e0;
      w0 = wr_total; e0 = err_total;
      send_frame(16'h85AA, 16);
      tests++;
      if (err_total - e0 !== 1) begin
         fails++; $display("FAIL bad_addr_err: got %0d want 1", err_total - e0);
      end
      tests++;
      if (regs_now() !== 40'hF0_00_00_00_55) begin
         fails++; $display("FAIL bad_addr_regs: got %h want %h", regs_now(), 40'hF0_00_00_00_55);
      end
      e0 = err_total;
      send_frame(16'h8233, 15);
      tests++;
      if (err_total - e0 !== 1) begin
         fails++; $display("FAIL short_frame_err: got %0d want 1", err_total - e0);
      end
      tests++;
      if (en_reg_pwm_7_0 !== 8'h00) begin
         fails++; $display("FAIL short_frame_pwm: got %h want 00", en_reg_pwm_7_0);
      end
      tests++;
      if (wr_total - w0 !== 0) begin
         fails++; $display("FAIL invalid_wr: got %0d want 0", wr_total - w0);
      end
   endtask

   task automatic test_read_and_idle_sclk();
      int w0, e0;
      w0 = wr_total; e0 = err_total;
      send_frame(16'h0312, 16);
      tests++;
      if (regs_now() !== 40'hF0_00_00_00_55) begin
         fails++; $display("FAIL read_regs: got %h want %h", regs_now(), 40'hF0_00_00_00_55);
      end
      tests++;
      if ((wr_total - w0) + (err_total - e0) !== 0) begin
         fails++; $display("FAIL read_strobes: got %0d want 0", (wr_total - w0) + (err_total - e0));
      end
      send_bits(16'h84C3, 0, 7);
      repeat (14) @(negedge clk);
      tests++;
      if (regs_now() !== 40'hF0_00_00_00_55) begin
         fails++; $display("FAIL ncs_high_regs: got %h want %h", regs_now(), 40'hF0_00_00_00_55);
      end
      tests++;
      if ((wr_total - w0) + (err_total - e0) !== 0) begin
         fails++; $display("FAIL ncs_high_strobes: got %0d want 0", (wr_total - w0) + (err_total - e0));
      end
   endtask

   task automatic test_reset_mid_frame();
      int w0, e0;
      begin_frame();
      send_bits(16'h84FF, 0, 9);
      rst = 1'b1;
      repeat (3) @(negedge clk);
      tests++;
      if (regs_now() !== 40'h0) begin
         fails++; $display("FAIL midrst_clear: got %h want %h", regs_now(), 40'h0);
      end
      rst = 1'b0;
      w0 = wr_total; e0 = err_total;
      send_bits(16'h84FF, 10, 15);
      end_frame();
      tests++;
      if (pwm_duty_cycle !== 8'h00) begin
         fails++; $display("FAIL midrst_pwm: got %h want 00", pwm_duty_cycle);
      end
      tests++;
      if ((wr_total - w0) + (err_total - e0) !== 0) begin
         fails++; $display("FAIL midrst_strobes: got %0d want 0", (wr_total - w0) + (err_total - e0));
      end
      w0 = wr_total;
      send_frame(16'h8401, 16);
      tests++;
      if (regs_now() !== 40'h00_00_00_00_01) begin
         fails++; $display("FAIL post_rst_write: got %h want %h", regs_now(), 40'h01);
      end
      tests++;
      if (wr_total - w0 !== 1) begin
         fails++; $display("FAIL post_rst_wr: got %0d want 1", wr_total - w0);
      end
   endtask

   initial begin
      test_reset();
      test_pwm_write();
      test_back_to_back();
      test_invalid();
      test_read_and_idle_sclk();
      test_reset_mid_frame();
      tests++;
      if (both_total !== 0) begin
         fails++; $display("FAIL strobe_exclusive: got %0d want 0", both_total);
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/spi_reg_writer.md
SPI_REG_WRITER -- requirements
Module: spi_reg_writer

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, number of flip-flops in each input synchronizer (legal range 2..3).
REQ-002 SHALL have parameter NUM_REGS, default 5, number of writable 8-bit registers at addresses 0..NUM_REGS-1.
REQ-003 SHALL have port clk  input  1  system clock; one clock domain only; all state on its rising edge.
REQ-004 SHALL have port rst  input  1  reset; asynchronous and active-high.
REQ-005 SHALL have port sclk  input  1  SPI serial clock, asynchronous to clk.
REQ-006 SHALL have port copi  input  1  SPI controller-out data, asynchronous to clk.
REQ-007 SHALL have port ncs  input  1  SPI chip select, active-low, asynchronous to clk.
REQ-008 SHALL have outputs en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8 and pwm_duty_cycle, each 8 bits, at addresses 0x00..0x04.
REQ-009 SHALL have port wr_strobe  output  1  one-clk pulse on every committed register write.
REQ-010 SHALL have port err_strobe  output  1  one-clk pulse on every discarded transaction.

Function
REQ-011 SHALL pass sclk, copi and ncs through SYNC_STAGES-deep synchronizers; all logic uses synchronized copies only.
REQ-012 SHALL detect sclk rising edge as synchronized sclk = 1 with its previous-cycle value = 0; ncs edges are detected the same way.
REQ-013 SHALL use SPI mode 0: MSB first, copi sampled on the synchronized sclk rising edge.
REQ-014 SHALL treat a frame as 16 bits: bit15 = R/W (1 = write), bits14:8 = address, bits7:0 = data.
REQ-015 SHALL implement the FSM states WAIT_HIGH, IDLE, SHIFT and COMMIT.
REQ-016 WAIT_HIGH: entered on reset; -> IDLE on the first cycle synchronized ncs = 1; sclk edges are ignored.
REQ-017 IDLE: ncs falling edge -> SHIFT, clearing the 16-bit shift register and the 5-bit bit counter.
REQ-018 SHIFT: each sclk rising edge shifts copi into bit 0 and increments the counter; the counter saturates at 31; ncs rising edge -> COMMIT.
REQ-019 COMMIT (exactly one cycle): a write is valid iff count == 16, bit15 = 1 and address < NUM_REGS; always -> IDLE next cycle.
REQ-020 Valid write: the addressed register takes the data byte, and wr_strobe = 1, both in the cycle after COMMIT (the register is visible then).
REQ-021 Invalid frame (count != 16, or address >= NUM_REGS): no register changes; err_strobe = 1 in the cycle after COMMIT.
REQ-022 Read frame (bit15 = 0) with count == 16: ignored silently; no strobe.
REQ-023 sclk edges while synchronized ncs = 1 SHALL have no effect in any state.
REQ-024 An sclk rising edge and an ncs rising edge detected in the same cycle: the ncs edge wins and the sclk edge is not counted.
REQ-025 Registers are never modified except through REQ-020; wr_strobe and err_strobe are never both 1.

Reset
REQ-026 While rst = 1: all five registers = 0x00, wr_strobe = 0, err_strobe = 0, shift register and counter = 0, FSM = WAIT_HIGH, synchronizer flops for sclk/copi = 0 and for ncs = 1.
REQ-027 Reset mid-frame SHALL discard the frame; a frame whose ncs is already low at reset release is never committed (WAIT_HIGH blocks it).

Verification
REQ-028 Frame 0x8455 with clk at 10x the sclk rate -> pwm_duty_cycle = 0x55, wr_strobe pulses once, other registers remain 0x00.
REQ-029 Frames 0x80F0 then 0x8100 -> en_reg_out_7_0 = 0xF0 and en_reg_out_15_8 = 0x00; exactly two wr_strobe pulses.
REQ-030 Frame 0x85AA (address 5) -> no register change, one err_strobe pulse; 15-bit frame 0x8233 truncated -> err_strobe, en_reg_pwm_7_0 unchanged.
REQ-031 Read frame 0x0312 -> no change, no strobes; sclk toggled 8 times with ncs high -> no change.
REQ-032 Assert rst after bit 9 of frame 0x84FF, release it with ncs still low, finish the frame -> pwm_duty_cycle = 0x00, no strobe; next frame 0x8401 -> 0x01.
